mult_28x20_rr_scheduler: RTL and testbench

//   Shares one pipelined 28x20 unsigned multiplier among N_REQ requesters.

---
 rtl/mult_sched_pkg.sv | 21 ++
 rtl/mult_28x20_pipe.sv | 37 +++
 rtl/mult_28x20_rr_scheduler.sv | 55 +++++
 tb/tb_mult_28x20_rr_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared widths, stage record and round-robin pick for the multiplier scheduler
package mult_sched_pkg;
  localparam int A_W = 28;
  localparam int B_W = 20;
  localparam int Y_W = 48;
  typedef struct packed {
    logic           valid;
    logic [2:0]     id;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [Y_W-1:0] y;
  } stage_t;
  function automatic logic [2:0] rr_pick(input logic [7:0] valid_vec, input logic [2:0] ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && valid_vec[idx]) rr_pick = 3'(idx);
    end
  endfunction
endpackage

// File: rtl/mult_28x20_pipe.sv
// mult_28x20_pipe: enable-gated registered 28x20 unsigned multiplier, PIPE register stages deep
module mult_28x20_pipe
  import mult_sched_pkg::*;
#(
  parameter int PIPE = 2
) (
  input  logic           clock0,
  input  logic           reset,
  input  logic           en,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [Y_W-1:0] y
);
  if (PIPE == 1) begin : g_one
    // single stage: operands multiplied and the product registered directly
    always_ff @(posedge clock0)
      if (reset) y <= '0;
      else if (en) y <= Y_W'(a) * Y_W'(b);
  end else begin : g_multi
    logic [A_W-1:0] a_r;
    logic [B_W-1:0] b_r;
    logic [Y_W-1:0] p [PIPE-1];
    // operand register, product register, then plain delay stages
    always_ff @(posedge clock0)
      if (reset) begin
        a_r <= '0;
        b_r <= '0;
        for (int k = 0; k < PIPE - 1; k++) p[k] <= '0;
      end else if (en) begin
        a_r <= a;
        b_r <= b;
        p[0] <= Y_W'(a_r) * Y_W'(b_r);
        for (int k = 1; k < PIPE - 1; k++) p[k] <= p[k-1];
      end
    assign y = p[PIPE-2];
  end
endmodule

// File: rtl/mult_28x20_rr_scheduler.sv
// mult_28x20_rr_scheduler: round-robin sharing of one pipelined 28x20 multiplier with tagged, backpressured results
module mult_28x20_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PIPE = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clock0,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [Y_W-1:0]         res_y,
  output logic                   busy
);
  logic            adv, hs;
  logic [ID_W-1:0] grant, rr_ptr;
  logic [PIPE-1:0] vld;
  logic [ID_W-1:0] tag [PIPE];
  // pick the next requester from rr_ptr; grant only when the pipeline can move
  always_comb begin
    adv = !res_valid || res_ready;
    grant = ID_W'(rr_pick(8'(req_valid), 3'(rr_ptr), N_REQ));
    hs = adv && |req_valid;
    req_ready = hs ? N_REQ'(1) << grant : '0;
  end
  // valid/tag shift chain alongside the datapath; bubbles shift like real ops
  always_ff @(posedge clock0)
    if (reset) begin
      vld <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < PIPE; k++) tag[k] <= '0;
    end else if (adv) begin
      vld <= PIPE'({vld, hs});
      tag[0] <= grant;
      for (int k = 1; k < PIPE; k++) tag[k] <= tag[k-1];
      if (hs) rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end
  mult_28x20_pipe #(.PIPE(PIPE)) u_pipe (
    .clock0(clock0),
    .reset(reset),
    .en(adv),
    .a(req_a[grant*A_W +: A_W]),
    .b(req_b[grant*B_W +: B_W]),
    .y(res_y)
  );
  assign res_valid = vld[PIPE-1];
  assign res_id = tag[PIPE-1];
  assign busy = |vld;
endmodule

// File: tb/tb_mult_28x20_rr_scheduler.sv
// tb_mult_28x20_rr_scheduler: table, directed and random checks against a cycle-level behavioural model
module tb_mult_28x20_rr_scheduler;
  localparam int N = 4;
  localparam int P = 2;
  typedef struct { bit v; int id; logic [47:0] y; } slot_t;
  typedef struct { int id; logic [27:0] a; logic [19:0] b; logic [47:0] y; } vec_t;
  logic clock0 = 0, reset = 1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*28-1:0] req_a = '0;
  logic [N*20-1:0] req_b = '0;
  logic res_valid, res_ready = 1, busy;
  logic [1:0] res_id;
  logic [47:0] res_y;
  int checks = 0, errors = 0;
  slot_t sl [P];
  int ptr = 0;

  mult_28x20_rr_scheduler #(.N_REQ(N), .PIPE(P)) dut (
    .clock0(clock0), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_y(res_y), .busy(busy)
  );

  always #5 clock0 = ~clock0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [27:0] a, input logic [19:0] b);
    req_a[i*28 +: 28] = a;
    req_b[i*20 +: 20] = b;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clock0);
    #1;
    for (int k = 0; k < P; k++) sl[k] = '{0, 0, 48'd0};
    ptr = 0;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_res_id", res_id, 0);
    reset = 0;
  endtask

  // one clock: compare DUT against the model, then advance the model on the edge
  task automatic tick(output logic [N-1:0] hs_o);
    bit adv, anyv;
    int g;
    logic [N-1:0] exp_rdy;
    logic [27:0] ga;
    logic [19:0] gb;
    slot_t nw;
    #1;
    adv = !sl[P-1].v || res_ready;
    g = -1;
    if (adv)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
    exp_rdy = (g >= 0) ? 4'(1) << g : 4'd0;
    anyv = 0;
    for (int k = 0; k < P; k++) anyv |= sl[k].v;
    chk("req_ready", req_ready, exp_rdy);
    chk("res_valid", res_valid, sl[P-1].v);
    if (sl[P-1].v) begin
      chk("res_y", res_y, sl[P-1].y);
      chk("res_id", res_id, sl[P-1].id);
    end
    chk("busy", busy, anyv);
    hs_o = req_valid & req_ready;
    nw = '{0, 0, 48'd0};
    if (g >= 0) begin
      ga = req_a[g*28 +: 28];
      gb = req_b[g*20 +: 20];
      nw = '{1, g, 48'(ga) * 48'(gb)};
    end
    @(posedge clock0);
    if (adv) begin
      for (int k = P - 1; k > 0; k--) sl[k] = sl[k-1];
      sl[0] = nw;
      if (g >= 0) ptr = (g + 1) % N;
    end
    #1;
  endtask

  initial begin
    vec_t tbl [6];
    logic [N-1:0] hs;
    logic [47:0] hy;
    logic [1:0] hid;
    int n, done, cyc;
    bit [N-1:0] pend;
    int wcnt [N];
    tbl[0] = '{0, 28'd3, 20'd5, 48'd15};
    tbl[1] = '{1, 28'hFFFFFFF, 20'hFFFFF, 48'hFFFFEFF00001};
    tbl[2] = '{2, 28'd0, 20'hFFFFF, 48'd0};
    tbl[3] = '{3, 28'hFFFFFFF, 20'd1, 48'hFFFFFFF};
    tbl[4] = '{0, 28'h8000000, 20'h80000, 48'h400000000000};
    tbl[5] = '{1, 28'h10000, 20'h10000, 48'h100000000};
    @(posedge clock0);
    do_reset();

    // single requests: latency, exact product, tag, then idle
    foreach (tbl[i]) begin
      set_op(tbl[i].id, tbl[i].a, tbl[i].b);
      req_valid = 4'(1) << tbl[i].id;
      tick(hs);
      chk("t1_handshake", hs, 4'(1) << tbl[i].id);
      req_valid = '0;
      n = 1;
      while (!res_valid && n < 20) begin
        tick(hs);
        n++;
      end
      chk("t1_latency", n, P);
      chk("t1_res_y", res_y, tbl[i].y);
      chk("t1_res_id", res_id, tbl[i].id);
      tick(hs);
      chk("t1_idle_valid", res_valid, 0);
      chk("t1_idle_busy", busy, 0);
    end

    // all requesters always valid: grants and result tags rotate 0,1,2,3 with no gaps
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 28'(i + 1), 20'(i + 10));
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      tick(hs);
      chk("t3_grant", hs, 4'(1) << (k % N));
      if (k >= P - 1) begin
        chk("t3_res_valid", res_valid, 1);
        chk("t3_res_id", res_id, (k - P + 1) % N);
      end
    end

    // backpressure: outputs frozen, no grants, then in-order drain with nothing lost
    res_ready = 0;
    hy = res_y;
    hid = res_id;
    for (int k = 0; k < 5; k++) begin
      tick(hs);
      chk("t4_no_grant", hs, 0);
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_y", res_y, hy);
      chk("t4_hold_id", res_id, hid);
    end
    res_ready = 1;
    req_valid = '0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (res_valid) n++;
      tick(hs);
    end
    chk("t4_drained", n, P);

    // reset with two operations in flight drops them
    do_reset();
    req_valid = '1;
    tick(hs);
    tick(hs);
    do_reset();
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick(hs);
    chk("t5_no_stale", res_valid, 0);

    // random traffic with random backpressure
    do_reset();
    pend = '0;
    foreach (wcnt[i]) wcnt[i] = 0;
    done = 0;
    cyc = 0;
    while (done < 10000 && cyc < 60000) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          set_op(i, ($urandom_range(0, 7) == 0) ? 28'hFFFFFFF : 28'($urandom),
                    ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom));
        end
      req_valid = pend;
      res_ready = $urandom_range(0, 3) != 0;
      tick(hs);
      for (int i = 0; i < N; i++)
        if (hs[i]) begin
          chk("t6_fairness", wcnt[i] < N, 1);
          wcnt[i] = 0;
          pend[i] = 0;
          done++;
        end else if (pend[i] && |hs) wcnt[i]++;
      cyc++;
    end
    chk("t6_ops_issued", done >= 10000, 1);
    req_valid = '0;
    res_ready = 1;
    for (int k = 0; k < P + 2; k++) tick(hs);
    chk("t6_final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
